// File: rtl/call_request_bank.sv
// call_request_bank
//   Latches hall up/down calls and car calls for an 8-floor elevator, holds
//   each one until the car serves it, tracks the service direction
//   (IDLE/UP/DN) and registers the next target floor for the motion
//   controller.
//
// Ports
//   clk, rst         single clock, synchronous active-high reset
//   btup[7:1]        hall up buttons (level)
//   btdn[8:2]        hall down buttons (level)
//   in_bt_floor[8:1] car buttons (level)
//   cur_floor[3:0]   current floor, legal 1..8
//   serve_stb        one-cycle pulse when the door opens at cur_floor
//   door_open        door currently open
//   reg_btup/reg_btdn/reg_in_bt_floor  latched requests
//   req_above/req_below/req_here       any latched request relative to cur_floor
//   dir_up/dir_dn    direction state, both low = IDLE
//   tgt_floor/tgt_valid                next target floor (0 when invalid)
//
// Build option
//   CALL_DEBOUNCE_EN : when defined, every button bit must be high for
//   DEB_CYCLES consecutive samples before it counts as a press.
module call_request_bank #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:1] btup,
  input  logic [8:2] btdn,
  input  logic [8:1] in_bt_floor,
  input  logic [3:0] cur_floor,
  input  logic       serve_stb,
  input  logic       door_open,
  output logic [7:1] reg_btup,
  output logic [8:2] reg_btdn,
  output logic [8:1] reg_in_bt_floor,
  output logic       req_above,
  output logic       req_below,
  output logic       req_here,
  output logic       dir_up,
  output logic       dir_dn,
  output logic [3:0] tgt_floor,
  output logic       tgt_valid
);

  if (DEB_CYCLES == 0 || DEB_CYCLES > 15) begin : g_deb_range
    $error("DEB_CYCLES must be within 1..15");
  end

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_UP = 2'd1, ST_DN = 2'd2} state_e;

  localparam int NBTN = 22;

  // All 22 buttons in one vector: [6:0] up 1..7, [13:7] down 2..8, [21:14] car 1..8
  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] lvl_d, lvl_q;
  logic [NBTN-1:0] prev_d, prev_q;
  logic [NBTN-1:0] press;

  assign btn_raw = {in_bt_floor, btdn, btup};

`ifdef CALL_DEBOUNCE_EN
  localparam logic [3:0] DEB = 4'(DEB_CYCLES);
  logic [NBTN-1:0][3:0] cnt_d, cnt_q;

  // Count consecutive high samples, saturating at DEB. The accepted level
  // rises on the sample that completes the run and drops on any low sample,
  // so the edge detector below re-arms only after release.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (!btn_raw[i])         cnt_d[i] = 4'd0;
      else if (cnt_q[i] != DEB) cnt_d[i] = cnt_q[i] + 4'd1;
      lvl_d[i] = (cnt_d[i] == DEB);
    end
  end
`else
  always_comb lvl_d = btn_raw;
`endif

  always_comb prev_d = lvl_q;

  // Rising edge of the sampled level: one press per hold.
  assign press = lvl_q & ~prev_q;

  logic [7:1] pr_up;
  logic [8:2] pr_dn;
  logic [8:1] pr_car;
  assign pr_up  = press[6:0];
  assign pr_dn  = press[13:7];
  assign pr_car = press[21:14];

  // Request storage
  logic [7:1] up_d, up_q;
  logic [8:2] dn_d, dn_q;
  logic [8:1] car_d, car_q;
  logic [8:1] up_v, dn_v, any_v;

  assign up_v  = {1'b0, up_q};
  assign dn_v  = {dn_q, 1'b0};
  assign any_v = up_v | dn_v | car_q;

  // Floor-relative view of the latched requests
  logic       fl_ok, serve_ok;
  logic       up_hit, dn_hit, here_hit, up_closer;
  logic [3:0] up_fl, dn_fl, idle_fl;

  always_comb begin
    fl_ok    = (cur_floor >= 4'd1) && (cur_floor <= 4'd8);
    serve_ok = serve_stb && fl_ok;
    up_hit   = 1'b0;
    dn_hit   = 1'b0;
    here_hit = 1'b0;
    up_fl    = 4'd0;
    dn_fl    = 4'd0;
    // Descending scan leaves the nearest floor above in up_fl.
    for (int f = 8; f >= 1; f--) begin
      if (fl_ok && any_v[f] && (4'(f) > cur_floor)) begin
        up_hit = 1'b1;
        up_fl  = 4'(f);
      end
    end
    // Ascending scan leaves the nearest floor below in dn_fl.
    for (int f = 1; f <= 8; f++) begin
      if (fl_ok && any_v[f] && (4'(f) < cur_floor)) begin
        dn_hit = 1'b1;
        dn_fl  = 4'(f);
      end
      if (fl_ok && any_v[f] && (4'(f) == cur_floor)) here_hit = 1'b1;
    end
    // Strictly closer above wins; an equal distance resolves downward.
    up_closer = (up_fl - cur_floor) < (cur_floor - dn_fl);
    if (here_hit)              idle_fl = cur_floor;
    else if (up_hit && dn_hit) idle_fl = up_closer ? up_fl : dn_fl;
    else if (up_hit)           idle_fl = up_fl;
    else                       idle_fl = dn_fl;
  end

  assign req_above = up_hit;
  assign req_below = dn_hit;
  assign req_here  = here_hit;

  state_e state_d, state_q;

  // Set, then clear: a serve in the same cycle as a press on the same bit wins.
  always_comb begin
    up_d  = up_q;
    dn_d  = dn_q;
    car_d = car_q;

    // Presses at the open door's floor are absorbed when the car will serve
    // them right now: car calls always, hall calls matching the direction,
    // and any hall call while idle.
    for (int f = 1; f <= 7; f++)
      if (pr_up[f] && !(door_open && cur_floor == 4'(f) && state_q != ST_DN))
        up_d[f] = 1'b1;
    for (int f = 2; f <= 8; f++)
      if (pr_dn[f] && !(door_open && cur_floor == 4'(f) && state_q != ST_UP))
        dn_d[f] = 1'b1;
    for (int f = 1; f <= 8; f++)
      if (pr_car[f] && !(door_open && cur_floor == 4'(f)))
        car_d[f] = 1'b1;

    if (serve_ok) begin
      for (int f = 1; f <= 8; f++)
        if (cur_floor == 4'(f)) car_d[f] = 1'b0;
      // Opposite-direction hall call at f clears only on turnaround.
      for (int f = 1; f <= 7; f++)
        if (cur_floor == 4'(f) && (state_q != ST_DN || !dn_hit)) up_d[f] = 1'b0;
      for (int f = 2; f <= 8; f++)
        if (cur_floor == 4'(f) && (state_q != ST_UP || !up_hit)) dn_d[f] = 1'b0;
    end
  end

  // Direction
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (up_hit && dn_hit) state_d = up_closer ? ST_UP : ST_DN;
        else if (up_hit)      state_d = ST_UP;
        else if (dn_hit)      state_d = ST_DN;
      end
      ST_UP:   if (serve_ok && !up_hit) state_d = dn_hit ? ST_DN : ST_IDLE;
      ST_DN:   if (serve_ok && !dn_hit) state_d = up_hit ? ST_UP : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Target: keep going in the current direction; with nothing left that way
  // (or when idle) fall back to the nearest request anywhere.
  logic [3:0] tgt_floor_d, tgt_floor_q;
  logic       tgt_valid_d, tgt_valid_q;
  logic       dir_up_d, dir_up_q, dir_dn_d, dir_dn_q;

  always_comb begin
    if (!fl_ok)                         tgt_floor_d = 4'd0;
    else if (state_q == ST_UP && up_hit) tgt_floor_d = up_fl;
    else if (state_q == ST_DN && dn_hit) tgt_floor_d = dn_fl;
    else                                tgt_floor_d = idle_fl;
    tgt_valid_d = (tgt_floor_d != 4'd0);
    dir_up_d    = (state_d == ST_UP);
    dir_dn_d    = (state_d == ST_DN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q       <= '0;
      prev_q      <= '0;
      up_q        <= '0;
      dn_q        <= '0;
      car_q       <= '0;
      state_q     <= ST_IDLE;
      dir_up_q    <= 1'b0;
      dir_dn_q    <= 1'b0;
      tgt_floor_q <= 4'd0;
      tgt_valid_q <= 1'b0;
`ifdef CALL_DEBOUNCE_EN
      cnt_q       <= '0;
`endif
    end else begin
      lvl_q       <= lvl_d;
      prev_q      <= prev_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
      car_q       <= car_d;
      state_q     <= state_d;
      dir_up_q    <= dir_up_d;
      dir_dn_q    <= dir_dn_d;
      tgt_floor_q <= tgt_floor_d;
      tgt_valid_q <= tgt_valid_d;
`ifdef CALL_DEBOUNCE_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign reg_btup        = up_q;
  assign reg_btdn        = dn_q;
  assign reg_in_bt_floor = car_q;
  assign dir_up          = dir_up_q;
  assign dir_dn          = dir_dn_q;
  assign tgt_floor       = tgt_floor_q;
  assign tgt_valid       = tgt_valid_q;

endmodule

// File: tb/tb_call_request_bank.sv
// Bench for call_request_bank: directed scenarios with constant expectations,
// then randomized traffic checked every cycle against a floor-array model.
module tb_call_request_bank;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:1] btup = '0;
  logic [8:2] btdn = '0;
  logic [8:1] in_bt_floor = '0;
  logic [3:0] cur_floor = 4'd1;
  logic       serve_stb = 1'b0, door_open = 1'b0;
  logic [7:1] reg_btup;
  logic [8:2] reg_btdn;
  logic [8:1] reg_in_bt_floor;
  logic       req_above, req_below, req_here, dir_up, dir_dn, tgt_valid;
  logic [3:0] tgt_floor;

  always #5 clk = ~clk;

  call_request_bank #(.DEB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .btup(btup), .btdn(btdn), .in_bt_floor(in_bt_floor),
    .cur_floor(cur_floor), .serve_stb(serve_stb), .door_open(door_open),
    .reg_btup(reg_btup), .reg_btdn(reg_btdn), .reg_in_bt_floor(reg_in_bt_floor),
    .req_above(req_above), .req_below(req_below), .req_here(req_here),
    .dir_up(dir_up), .dir_dn(dir_dn), .tgt_floor(tgt_floor), .tgt_valid(tgt_valid)
  );

  int n_chk = 0, n_pass = 0;

`ifdef CALL_DEBOUNCE_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif

  // ---------------- reference model ----------------
  // Requests per floor; state 0 idle, 1 up, 2 down.
  bit m_up[1:8], m_dn[1:8], m_car[1:8];
  int m_state = 0, m_tgt = 0;
  int hist[3][1:8];
  bit pend[3][1:8];

  function automatic bit m_any(int f);
    return m_up[f] | m_dn[f] | m_car[f];
  endfunction
  function automatic bit m_legal();
    return (cur_floor >= 1) && (cur_floor <= 8);
  endfunction
  function automatic int m_above();
    if (!m_legal()) return 0;
    for (int f = int'(cur_floor) + 1; f <= 8; f++) if (m_any(f)) return f;
    return 0;
  endfunction
  function automatic int m_below();
    if (!m_legal()) return 0;
    for (int f = int'(cur_floor) - 1; f >= 1; f--) if (m_any(f)) return f;
    return 0;
  endfunction
  function automatic bit m_here();
    return m_legal() && m_any(int'(cur_floor));
  endfunction
  function automatic bit m_btn(int k, int f);
    logic [8:1] bu, bd;
    bu = {1'b0, btup};
    bd = {btdn, 1'b0};
    case (k)
      0: return bu[f];
      1: return bd[f];
      default: return in_bt_floor[f];
    endcase
  endfunction
  function automatic logic [7:1] m_pack_up();
    logic [7:1] r;
    for (int f = 1; f <= 7; f++) r[f] = m_up[f];
    return r;
  endfunction
  function automatic logic [8:2] m_pack_dn();
    logic [8:2] r;
    for (int f = 2; f <= 8; f++) r[f] = m_dn[f];
    return r;
  endfunction
  function automatic logic [8:1] m_pack_car();
    logic [8:1] r;
    for (int f = 1; f <= 8; f++) r[f] = m_car[f];
    return r;
  endfunction

  always @(posedge clk) begin : model
    int c, na, nb, nst, ntg, nh;
    bit lg, b;
    if (rst) begin
      for (int f = 1; f <= 8; f++) begin
        m_up[f] = 0; m_dn[f] = 0; m_car[f] = 0;
        for (int k = 0; k < 3; k++) begin hist[k][f] = 0; pend[k][f] = 0; end
      end
      m_state = 0;
      m_tgt = 0;
    end else begin
      c = int'(cur_floor);
      lg = m_legal();
      na = m_above();
      nb = m_below();
      if (!lg) ntg = 0;
      else if (m_state == 1 && na != 0) ntg = na;
      else if (m_state == 2 && nb != 0) ntg = nb;
      else if (m_here()) ntg = c;
      else if (na != 0 && nb != 0) ntg = (na - c < c - nb) ? na : nb;
      else ntg = (na != 0) ? na : nb;
      nst = m_state;
      case (m_state)
        0: if (na != 0 && nb != 0) nst = (na - c < c - nb) ? 1 : 2;
           else if (na != 0) nst = 1;
           else if (nb != 0) nst = 2;
        1: if (serve_stb && lg && na == 0) nst = (nb != 0) ? 2 : 0;
        default: if (serve_stb && lg && nb == 0) nst = (na != 0) ? 1 : 0;
      endcase
      for (int k = 0; k < 3; k++)
        for (int f = 1; f <= 8; f++)
          if (pend[k][f] && !(door_open && f == c && (k == 2 || m_state == 0 || k + 1 == m_state))) begin
            if (k == 0) m_up[f] = 1;
            else if (k == 1) m_dn[f] = 1;
            else m_car[f] = 1;
          end
      if (serve_stb && lg) begin
        m_car[c] = 0;
        if (m_state != 2 || nb == 0) m_up[c] = 0;
        if (m_state != 1 || na == 0) m_dn[c] = 0;
      end
      for (int k = 0; k < 3; k++)
        for (int f = 1; f <= 8; f++) begin
          b = m_btn(k, f);
          nh = b ? ((hist[k][f] < D) ? hist[k][f] + 1 : hist[k][f]) : 0;
          pend[k][f] = (nh == D) && (hist[k][f] < D);
          hist[k][f] = nh;
        end
      m_state = nst;
      m_tgt = ntg;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    tick(2);
    n_chk++;
    if ({reg_btup, reg_btdn, reg_in_bt_floor, dir_up, dir_dn, tgt_floor, tgt_valid} !== '0)
      $display("FAIL reset_state: got up=%b dn=%b car=%b dir=%b%b tgt=%0d v=%b want all 0",
               reg_btup, reg_btdn, reg_in_bt_floor, dir_up, dir_dn, tgt_floor, tgt_valid);
    else n_pass++;
    rst = 1'b0; cur_floor = 4'd1;
    btup = 7'b0010000;
    tick();
    n_chk++;
    if (reg_btup !== 7'b0000000) $display("FAIL press_latency_early: got %b want 0000000", reg_btup);
    else n_pass++;
    tick();
    n_chk++;
    if (reg_btup !== 7'b0010000 || req_above !== 1'b1)
      $display("FAIL press_set: got %b above=%b want 0010000 above=1", reg_btup, req_above);
    else n_pass++;
    tick();
    n_chk++;
    if (dir_up !== 1'b1 || tgt_floor !== 4'd5 || tgt_valid !== 1'b1)
      $display("FAIL first_target: got up=%b tgt=%0d v=%b want up=1 tgt=5 v=1", dir_up, tgt_floor, tgt_valid);
    else n_pass++;
    cur_floor = 4'd5; door_open = 1'b1;
    tick();
    serve_stb = 1'b1; tick(); serve_stb = 1'b0;
    n_chk++;
    if (reg_btup !== 7'b0000000) $display("FAIL serve_clear_up5: got %b want 0000000", reg_btup);
    else n_pass++;
    tick(3);
    n_chk++;
    if (reg_btup !== 7'b0000000 || dir_up !== 1'b0 || dir_dn !== 1'b0 || tgt_valid !== 1'b0)
      $display("FAIL held_no_reset: got up=%b dir=%b%b v=%b want 0 idle v=0", reg_btup, dir_up, dir_dn, tgt_valid);
    else n_pass++;
    btup = '0; door_open = 1'b0;
    tick();
  endtask

  task automatic test_down_calls();
    logic [8:2] exp_dn;
    do_reset();
    cur_floor = 4'd8;
    btdn = 7'b0000111;
    tick(); btdn = '0; tick(3);
    n_chk++;
    if (dir_dn !== 1'b1 || tgt_floor !== 4'd4)
      $display("FAIL down_start: got dn=%b tgt=%0d want dn=1 tgt=4", dir_dn, tgt_floor);
    else n_pass++;
    exp_dn = 7'b0000111;
    for (int f = 4; f >= 2; f--) begin
      cur_floor = 4'(f);
      tick();
      serve_stb = 1'b1; tick(); serve_stb = 1'b0;
      exp_dn[f] = 1'b0;
      n_chk++;
      if (reg_btdn !== exp_dn) $display("FAIL down_clear_f%0d: got %b want %b", f, reg_btdn, exp_dn);
      else n_pass++;
      if (f > 2) begin
        tick();
        n_chk++;
        if (tgt_floor !== 4'(f - 1) || dir_dn !== 1'b1)
          $display("FAIL down_next_f%0d: got tgt=%0d dn=%b want tgt=%0d dn=1", f, tgt_floor, dir_dn, f - 1);
        else n_pass++;
      end
    end
    n_chk++;
    if (dir_dn !== 1'b0 || dir_up !== 1'b0) $display("FAIL down_idle: got dir=%b%b want 00", dir_up, dir_dn);
    else n_pass++;
    tick();
    n_chk++;
    if (tgt_valid !== 1'b0 || tgt_floor !== 4'd0)
      $display("FAIL down_no_target: got tgt=%0d v=%b want 0 0", tgt_floor, tgt_valid);
    else n_pass++;
  endtask

  task automatic test_turnaround();
    for (int v = 0; v < 2; v++) begin
      do_reset();
      cur_floor = 4'd1; door_open = 1'b0;
      btdn = 7'b0000100;
      in_bt_floor = (v == 1) ? 8'b00000001 : 8'b00000000;
      tick(); btdn = '0; in_bt_floor = '0; tick(3);
      n_chk++;
      if (dir_up !== 1'b1) $display("FAIL turn_up_v%0d: got up=%b want 1", v, dir_up);
      else n_pass++;
      cur_floor = 4'd4;
      tick();
      serve_stb = 1'b1; tick(); serve_stb = 1'b0;
      n_chk++;
      if (reg_btdn !== 7'b0000000 || dir_up !== 1'b0 || dir_dn !== 1'(v) || reg_in_bt_floor !== 8'(v))
        $display("FAIL turn_serve_v%0d: got dn_reg=%b dir=%b%b car=%b want dn_reg=0 dir=0%0d car=%0d",
                 v, reg_btdn, dir_up, dir_dn, reg_in_bt_floor, v, v);
      else n_pass++;
      tick();
      n_chk++;
      if (tgt_floor !== 4'(v) || tgt_valid !== 1'(v))
        $display("FAIL turn_target_v%0d: got tgt=%0d v=%b want %0d", v, tgt_floor, tgt_valid, v);
      else n_pass++;
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    cur_floor = 4'd3; door_open = 1'b0;
    in_bt_floor = 8'b00000100;
    tick();
    serve_stb = 1'b1; tick(); serve_stb = 1'b0;
    tick();
    n_chk++;
    if (reg_in_bt_floor !== 8'b00000000) $display("FAIL clear_wins: got %b want 00000000", reg_in_bt_floor);
    else n_pass++;
    in_bt_floor = '0; tick();
    door_open = 1'b1;
    in_bt_floor = 8'b00000100; btup = 7'b0000100;
    tick(); in_bt_floor = '0; btup = '0; tick(2);
    n_chk++;
    if (reg_in_bt_floor !== 8'b00000000 || reg_btup !== 7'b0000000)
      $display("FAIL door_absorb: got car=%b up=%b want 0 0", reg_in_bt_floor, reg_btup);
    else n_pass++;
    in_bt_floor = 8'b00100000;
    tick(); in_bt_floor = '0; tick();
    n_chk++;
    if (reg_in_bt_floor !== 8'b00100000) $display("FAIL door_other_floor: got %b want 00100000", reg_in_bt_floor);
    else n_pass++;
    door_open = 1'b0;
  endtask

  task automatic test_illegal_floor();
    do_reset();
    cur_floor = 4'd2; door_open = 1'b0;
    btup = 7'b0010000; btdn = 7'b0010010; in_bt_floor = 8'b01000001;
    tick(); btup = '0; btdn = '0; in_bt_floor = '0; tick(2);
    n_chk++;
    if (dir_dn !== 1'b1 || tgt_floor !== 4'd1)
      $display("FAIL tie_goes_down: got dn=%b tgt=%0d want dn=1 tgt=1", dir_dn, tgt_floor);
    else n_pass++;
    cur_floor = 4'd0; #1;
    n_chk++;
    if ({req_above, req_below, req_here} !== 3'b000)
      $display("FAIL illegal_req: got %b want 000", {req_above, req_below, req_here});
    else n_pass++;
    tick();
    n_chk++;
    if (tgt_valid !== 1'b0 || tgt_floor !== 4'd0)
      $display("FAIL illegal_tgt: got tgt=%0d v=%b want 0 0", tgt_floor, tgt_valid);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      cur_floor = (i == 0) ? 4'd0 : 4'd9;
      serve_stb = 1'b1; tick(); serve_stb = 1'b0;
      n_chk++;
      if (reg_btup !== 7'b0010000 || reg_btdn !== 7'b0010010 || reg_in_bt_floor !== 8'b01000001 || dir_dn !== 1'b1)
        $display("FAIL illegal_serve_%0d: got up=%b dn=%b car=%b dn_dir=%b want unchanged",
                 i, reg_btup, reg_btdn, reg_in_bt_floor, dir_dn);
      else n_pass++;
    end
    cur_floor = 4'd2;
    rst = 1'b1; tick(); rst = 1'b0;
    n_chk++;
    if ({reg_btup, reg_btdn, reg_in_bt_floor, req_above, req_below, req_here, dir_up, dir_dn, tgt_floor, tgt_valid} !== '0)
      $display("FAIL midrun_reset: got up=%b dn=%b car=%b req=%b%b%b dir=%b%b tgt=%0d v=%b want all 0",
               reg_btup, reg_btdn, reg_in_bt_floor, req_above, req_below, req_here, dir_up, dir_dn, tgt_floor, tgt_valid);
    else n_pass++;
  endtask

`ifdef CALL_DEBOUNCE_EN
  task automatic test_debounce();
    do_reset();
    cur_floor = 4'd1; door_open = 1'b0;
    btup = 7'b0000010; tick(3); btup = '0; tick(6);
    n_chk++;
    if (reg_btup !== 7'b0000000) $display("FAIL deb_short: got %b want 0", reg_btup);
    else n_pass++;
    btup = 7'b0000010; tick(2); btup = '0; tick(); btup = 7'b0000010; tick(2); btup = '0; tick(6);
    n_chk++;
    if (reg_btup !== 7'b0000000) $display("FAIL deb_glitch: got %b want 0", reg_btup);
    else n_pass++;
    btup = 7'b0000010; tick(4); btup = '0; tick(2);
    n_chk++;
    if (reg_btup !== 7'b0000010) $display("FAIL deb_accept: got %b want 0000010", reg_btup);
    else n_pass++;
  endtask
`endif

  task automatic test_random(int cycles);
    int v;
    for (int i = 0; i < cycles; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      btup ^= 7'($urandom & $urandom & $urandom & $urandom);
      btdn ^= 7'($urandom & $urandom & $urandom & $urandom);
      in_bt_floor ^= 8'($urandom & $urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 9) == 0) begin
          v = $urandom_range(0, 7);
          cur_floor = (v == 0) ? 4'd0 : 4'(8 + v);
        end else cur_floor = 4'($urandom_range(1, 8));
      end
      serve_stb = ($urandom_range(0, 4) == 0);
      door_open = 1'($urandom_range(0, 1));
      tick();
      n_chk++;
      if (reg_btup !== m_pack_up() || reg_btdn !== m_pack_dn() || reg_in_bt_floor !== m_pack_car())
        $display("FAIL rnd_regs c%0d: got %b/%b/%b want %b/%b/%b", i, reg_btup, reg_btdn, reg_in_bt_floor,
                 m_pack_up(), m_pack_dn(), m_pack_car());
      else n_pass++;
      n_chk++;
      if ({req_above, req_below, req_here} !== {m_above() != 0, m_below() != 0, m_here()})
        $display("FAIL rnd_req c%0d: got %b want %b", i, {req_above, req_below, req_here},
                 {m_above() != 0, m_below() != 0, m_here()});
      else n_pass++;
      n_chk++;
      if ({dir_up, dir_dn} !== {m_state == 1, m_state == 2})
        $display("FAIL rnd_dir c%0d: got %b%b want state %0d", i, dir_up, dir_dn, m_state);
      else n_pass++;
      n_chk++;
      if (tgt_floor !== 4'(m_tgt) || tgt_valid !== (m_tgt != 0))
        $display("FAIL rnd_tgt c%0d: got %0d/%b want %0d", i, tgt_floor, tgt_valid, m_tgt);
      else n_pass++;
    end
    rst = 1'b0; serve_stb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_down_calls();
    test_turnaround();
    test_same_cycle();
    test_illegal_floor();
`ifdef CALL_DEBOUNCE_EN
    test_debounce();
`endif
    test_random(4000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/call_request_bank.md
# call_request_bank

Latches hall calls (up/down) and car calls for the 8-floor elevator. Holds each request until the car serves it and tracks the service direction (IDLE/UP/DN). Produces the next target floor for the motion controller. It sits between the button inputs (`btup`, `btdn`, `in_bt_floor`) and the elevator controller, and is the source of the `reg_btup`/`reg_btdn`/`reg_in_bt_floor` registers whose falling edges release buttons.

## Interface
- `DEB_CYCLES`, 4, consecutive high cycles needed to accept a press (used only with `CALL_DEBOUNCE_EN`); legal range 1..15.
- `clk` in 1 — single clock, all state on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `btup` in [7:1] — hall up buttons, level, floors 1..7.
- `btdn` in [8:2] — hall down buttons, level, floors 2..8.
- `in_bt_floor` in [8:1] — car buttons, level.
- `cur_floor` in 4 — current floor, binary; legal values 1..8.
- `serve_stb` in 1 — one-cycle pulse when the door opens at `cur_floor`.
- `door_open` in 1 — high while the door is open.
- `reg_btup` out [7:1] — latched up calls.
- `reg_btdn` out [8:2] — latched down calls.
- `reg_in_bt_floor` out [8:1] — latched car calls.
- `req_above`, `req_below`, `req_here` out 1 each — any latched request above, below, or at `cur_floor`.
- `dir_up`, `dir_dn` out 1 each — direction state, one-hot; both 0 means IDLE.
- `tgt_floor` out 4 — next target floor, binary 1..8; 0 when invalid.
- `tgt_valid` out 1 — `tgt_floor` is meaningful.

## Operation
- **Press detection:** rising edge of each button bit, using a registered copy of the input. A held button sets the request once.
- **Set:** a detected edge sets the corresponding `reg_*` bit.
- **Press absorbed at an open door:** if `door_open`=1 and the press is at `cur_floor`, it is ignored when any of these holds:
  - it is a car button;
  - it is a hall call matching the current direction;
  - the block is IDLE.
- **Clear:** on `serve_stb` with a legal `cur_floor`=f, all of these occur:
  - `reg_in_bt_floor[f]` always clears;
  - UP: `reg_btup[f]` clears; `reg_btdn[f]` also clears if no request remains above f after the clear (turnaround);
  - DN: mirror of UP;
  - IDLE: all three bits at f clear.
  - Nonexistent bits are skipped: `btup` at floor 8, `btdn` at floor 1.
- **Illegal floor:** `cur_floor` = 0 or 9..15 causes `serve_stb` to be ignored, `req_above/below/here`=0, and `tgt_valid`=0.
- **Direction FSM** (state IDLE/UP/DN):
  - IDLE→UP when `req_above` and not `req_below`.
  - IDLE→DN when `req_below` and not `req_above`.
  - IDLE with both: go toward the nearest request; a distance tie goes DN.
  - UP→DN or IDLE on `serve_stb` when no request remains above: DN if `req_below`, else IDLE. DN→UP/IDLE is the mirror.
  - No other transitions.
- **Target:**
  - UP: nearest floor above `cur_floor` with any latched bit.
  - DN: nearest floor below with any latched bit.
  - IDLE: nearest request at any floor; a tie goes to the lower floor; `req_here` gives `cur_floor`.
  - With no requests: `tgt_valid`=0 and `tgt_floor`=0.

## Timing
- **Reset** (rst=1 at a clock edge): all `reg_*`=0, edge registers=0, state IDLE, `tgt_floor`=0, `tgt_valid`=0, debounce counters=0. Reset overrides any press or serve in the same cycle.
- **Press latency:** an input rising before edge n sets the `reg_*` bit at edge n+1, one cycle after sampling.
- **Clear latency:** `serve_stb` sampled at edge n clears the bit at edge n.
- **Set and clear in the same cycle on the same bit:** clear wins; the press is lost.
- **Derived outputs:** `req_*` are combinational from `reg_*` and `cur_floor`. FSM state and `tgt_*` are registered one cycle after the `reg_*` they depend on.
- **Back-to-back `serve_stb`:** each pulse is handled independently; no minimum spacing.

## Configuration
- **`CALL_DEBOUNCE_EN` defined:** each of the 22 button bits has a 4-bit counter. A press is accepted only after the input has been high for `DEB_CYCLES` consecutive samples; any low sample resets the counter. The bit sets at edge n+`DEB_CYCLES` after the first high sample. The bit re-arms only after the input returns low.
- **`CALL_DEBOUNCE_EN` undefined:** plain edge detect, latency per Timing; no counters are instantiated and `DEB_CYCLES` is unused.

## Test plan
- **Reset:** reset, then `btup[5]`=1 at `cur_floor`=1 → `reg_btup[5]`=1 one cycle later, then UP, then `tgt_floor`=5 and `tgt_valid`=1. Holding `btup[5]` high does not re-set the bit after it is served.
- **Down calls:** `btdn[2]`, `btdn[3]`, `btdn[4]` pressed at `cur_floor`=8 → DN; targets are 4, then 3, then 2 as `serve_stb` is pulsed at each floor; each `reg_btdn` bit falls on its serve; IDLE after floor 2.
- **Turnaround:** UP at floor 4 with `reg_btdn[4]`=1 and nothing above; `serve_stb` → `reg_btdn[4]` clears and the state becomes DN if `reg_in_bt_floor[1]` is set, otherwise IDLE.
- **Same-cycle conflict:** `in_bt_floor[3]` edge in the same cycle as `serve_stb` at `cur_floor`=3 → bit stays 0. A press at floor 3 with `door_open`=1 is ignored.
- **Illegal floor:** `cur_floor`=0 with `serve_stb` → no bits clear and `tgt_valid`=0. Reset asserted mid-run with 5 pending requests → all outputs at their reset values the next cycle.
- **Debounce (`CALL_DEBOUNCE_EN`, `DEB_CYCLES`=4):** a 3-cycle pulse on `btup[2]` is ignored; a 4-cycle pulse sets `reg_btup[2]`; glitches of high-low-high reset the count.
